// File: rtl/window_buffer3x3.sv
// Same-padded 3x3 window generator for a raster pixel stream of a W x W map.
// Two line buffers feed a 3x3 shift array; out-of-map taps are forced to +0.0.
module window_buffer3x3 #(
  parameter int DATA_WIDTH  = 32,
  parameter int IMAGE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic                    o_valid,
  output logic [9*DATA_WIDTH-1:0] o_window,
  output logic                    o_last,
  output logic                    o_busy
);

  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int FW = $clog2(IMAGE_WIDTH + 1);
  localparam logic [CW-1:0] LAST    = CW'(IMAGE_WIDTH - 1);
  localparam logic [FW-1:0] FL_LAST = FW'(IMAGE_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t state, state_nx;

  logic [CW-1:0] in_row, in_col, out_row, out_col;
  logic [FW-1:0] fl_cnt;

  logic [DATA_WIDTH-1:0] lb0 [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] win_p0 [3][3];
  logic [DATA_WIDTH-1:0] col_p0 [3];
  logic [8:0]            keep_p0;

  logic       accept, flush_step, step, in_last, emit;
  logic [2:0] row_ok, col_ok;
  logic [8:0] mask;

  assign accept     = i_valid && (state != S_FLUSH);
  assign flush_step = (state == S_FLUSH);
  assign step       = accept || flush_step;
  assign in_last    = (in_row == LAST) && (in_col == LAST);
  // A window is due once the pixel diagonally below-right of its centre arrives.
  assign emit       = flush_step ||
                      (accept && (in_row != '0) && !((in_row == CW'(1)) && (in_col == '0)));
  assign o_busy     = flush_step;

  always_comb begin
    row_ok = {out_row != LAST, 1'b1, out_row != '0};
    col_ok = {out_col != LAST, 1'b1, out_col != '0};
    mask   = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        mask[3*dr+dc] = row_ok[dr] & col_ok[dc];
  end

  always_comb begin
    col_p0[0] = lb0[in_col];
    col_p0[1] = lb1[in_col];
    col_p0[2] = flush_step ? '0 : i_data;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (accept && in_last) state_nx = S_FLUSH;
      S_FLUSH: if (fl_cnt == FL_LAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      in_row  <= '0;
      in_col  <= '0;
      out_row <= '0;
      out_col <= '0;
      fl_cnt  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      keep_p0 <= '0;
    end else begin
      state   <= state_nx;
      o_valid <= emit;
      o_last  <= emit && (out_row == LAST) && (out_col == LAST);
      if (step) keep_p0 <= emit ? mask : '0;
      if (accept) begin
        in_col <= (in_col == LAST) ? '0 : in_col + CW'(1);
        if (in_col == LAST) in_row <= (in_row == LAST) ? '0 : in_row + CW'(1);
      end
      if (flush_step) begin
        fl_cnt <= (fl_cnt == FL_LAST) ? '0 : fl_cnt + FW'(1);
        if (fl_cnt == FL_LAST) in_col <= '0;
        else                   in_col <= (in_col == LAST) ? '0 : in_col + CW'(1);
      end
      if (emit) begin
        out_col <= (out_col == LAST) ? '0 : out_col + CW'(1);
        if (out_col == LAST) out_row <= (out_row == LAST) ? '0 : out_row + CW'(1);
      end
    end
  end

  // Stage p0: line buffers age by one row, window array shifts one column left.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[in_col] <= lb1[in_col];
      lb1[in_col] <= i_data;
    end
    if (step) begin
      for (int dr = 0; dr < 3; dr++) begin
        win_p0[dr][0] <= win_p0[dr][1];
        win_p0[dr][1] <= win_p0[dr][2];
        win_p0[dr][2] <= col_p0[dr];
      end
    end
  end

  always_comb begin
    o_window = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        o_window[(3*dr+dc)*DATA_WIDTH +: DATA_WIDTH] =
          keep_p0[3*dr+dc] ? win_p0[dr][dc] : '0;
  end

endmodule

// File: tb/tb_window_buffer3x3.sv
// Directed bench for window_buffer3x3 (W=4): scoreboarded windows from a padded model.
module tb_window_buffer3x3;
  localparam int DW   = 32;
  localparam int W    = 4;
  localparam int NPIX = W * W;
  localparam int WW   = 9 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic [WW-1:0] o_window;
  logic          o_last;
  logic          o_busy;

  always #5 clk = ~clk;

  window_buffer3x3 #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_window(o_window), .o_last(o_last), .o_busy(o_busy)
  );

  typedef struct {
    logic [WW-1:0] win;
    logic          last;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   frame [NPIX];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] model_win(input int n);
    logic [WW-1:0] w;
    int r0, c0, rr, cc;
    w  = '0;
    r0 = n / W;
    c0 = n % W;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        rr = r0 + dr - 1;
        cc = c0 + dc - 1;
        if (rr >= 0 && rr < W && cc >= 0 && cc < W)
          w[(3*dr+dc)*DW +: DW] = DW'(frame[rr*W+cc]);
      end
    return w;
  endfunction

  task automatic push(input int n, input int due);
    exp_t e;
    e.win  = model_win(n);
    e.last = (n == NPIX - 1);
    e.due  = due;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", WW'(o_valid), WW'(0));
      end else begin
        e = sb.pop_front();
        check("window", o_window, e.win);
        check("last", WW'(o_last), WW'(e.last));
        check("timing", WW'(cyc), WW'(e.due));
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixel(input int v, input int k);
    i_valid = 1'b1;
    i_data  = DW'(v);
    if (k >= W + 1) push(k - W - 1, cyc + 1);
    if (k == NPIX - 1)
      for (int j = 0; j <= W; j++) push(NPIX - W - 1 + j, cyc + 2 + j);
    idle();
    i_valid = 1'b0;
  endtask

  task automatic chk_reset();
    check("rst_valid", WW'(o_valid), WW'(0));
    check("rst_last", WW'(o_last), WW'(0));
    check("rst_busy", WW'(o_busy), WW'(0));
    check("rst_window", o_window, WW'(0));
  endtask

  task automatic send_frame(input int base, input bit gaps);
    int            nb;
    int            ref6 [9];
    logic [WW-1:0] w6;
    for (int k = 0; k < NPIX; k++) frame[k] = base + k;
    for (int k = 0; k < NPIX; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) idle();
      drive_pixel(base + k, k);
      if (base == 1 && k == 5 && !gaps) begin
        ref6 = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        w6 = '0;
        for (int t = 0; t < 9; t++) w6[t*DW +: DW] = DW'(ref6[t]);
        check("first_window_valid", WW'(o_valid), WW'(1));
        check("first_window", o_window, w6);
      end
    end
    nb = 0;
    for (int t = 0; t < 20; t++) begin
      if (o_busy !== 1'b1) break;
      nb++;
      idle();
    end
    check("busy_cycles", WW'(nb), WW'(W + 1));
  endtask

  task automatic drain();
    repeat (4) idle();
    check("scoreboard_empty", WW'(sb.size()), WW'(0));
  endtask

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (3) idle();
    chk_reset();
    rst = 1'b0;
    idle();

    send_frame(1, 1'b0);
    drain();

    send_frame(1, 1'b1);
    drain();

    send_frame(100, 1'b0);
    send_frame(1, 1'b0);
    drain();

    for (int k = 0; k < NPIX; k++) frame[k] = 1 + k;
    for (int k = 0; k < 9; k++) drive_pixel(1 + k, k);
    rst = 1'b1;
    idle();
    chk_reset();
    idle();
    rst = 1'b0;
    check("reset_scoreboard", WW'(sb.size()), WW'(0));
    repeat (2) idle();
    send_frame(1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
